rv_decode_stage: RTL and testbench

RV_DECODE_STAGE -- requirements
Module: rv_decode

---
 rtl/rv_decode_pkg.sv | 84 ++++++++
 rtl/rv_imm_gen.sv | 31 +++
 rtl/rv_decode_stage.sv | 177 +++++++++++++++++
 tb/tb_rv_decode_stage.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/rv_decode_pkg.sv
// rtl/rv_decode_pkg.sv - shared constants, encodings and helpers for the RV32I decode stage
//
// Purpose:
//   Opcode constants, the result-select and ALU-operation encodings, the
//   immediate-format classification and the NOP word used on reset and flush.
//   Imported by rv_imm_gen and rv_decode_stage.
//
// Ports: none (package).

package rv_decode_pkg;

  // Major opcodes (instr[6:0])
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  // addi x0, x0, 0 : the canonical bubble
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [1:0] {
    RES_ALU    = 2'b00,
    RES_LOAD   = 2'b01,
    RES_PC_P4  = 2'b10,
    RES_PC_IMM = 2'b11
  } res_src_e;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'b000,
    ALU_SUB   = 3'b001,
    ALU_AND   = 3'b010,
    ALU_OR    = 3'b011,
    ALU_XOR   = 3'b100,
    ALU_SLT   = 3'b101,
    ALU_SLTU  = 3'b110,
    ALU_SHIFT = 3'b111
  } alu_ctrl_e;

  // R-type shares the I-type immediate layout, so it needs no format of its own.
  typedef enum logic [2:0] {
    FMT_I = 3'd0,
    FMT_S = 3'd1,
    FMT_B = 3'd2,
    FMT_U = 3'd3,
    FMT_J = 3'd4
  } imm_fmt_e;

  // Unknown opcodes (FENCE, SYSTEM, illegal) fall back to the I layout; the
  // value is harmless because such words decode as bubbles.
  function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
    imm_fmt_e fmt;
    case (opcode)
      OPC_STORE:           fmt = FMT_S;
      OPC_BRANCH:          fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:  fmt = FMT_U;
      OPC_JAL:             fmt = FMT_J;
      default:             fmt = FMT_I;
    endcase
    return fmt;
  endfunction

  // ALU operation selected by funct3 for OP / OP-IMM. The SUB override for
  // funct3=000 is applied by the caller since it only exists for OP.
  function automatic alu_ctrl_e alu_ctrl_of_funct3(input logic [2:0] funct3);
    alu_ctrl_e op;
    case (funct3)
      3'b000:  op = ALU_ADD;
      3'b001:  op = ALU_SHIFT;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = ALU_SHIFT;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/rv_imm_gen.sv
// rtl/rv_imm_gen.sv - sign-extended immediate generator for RV32I words
//
// Purpose:
//   Pure combinational extraction of the immediate field of an instruction,
//   with the layout chosen from the opcode.
//
// Ports:
//   instr  in  32  instruction word
//   imm    out 32  sign-extended immediate (I/S/B/U/J layouts; R uses I)

module rv_imm_gen
  import rv_decode_pkg::*;
(
  input  logic [31:0] instr,
  output logic [31:0] imm
);

  always_comb begin
    imm = {{20{instr[31]}}, instr[31:20]};
    case (imm_fmt_of(instr[6:0]))
      FMT_S: imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      FMT_B: imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      FMT_U: imm = {instr[31:12], 12'h000};
      FMT_J: imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = {{20{instr[31]}}, instr[31:20]};
    endcase
  end

endmodule

// File: rtl/rv_decode_stage.sv
// rtl/rv_decode_stage.sv - RV32I decode stage: stage register plus combinational decode
//
// Purpose:
//   Captures the fetched word and its PCs in a stage register (reset > flush >
//   stall > load-on-ack) and decodes register indices, immediate and control
//   flags combinationally from that register, one cycle after the ack edge.
//
// Ports:
//   i_clk, i_reset_n             clock (rising), synchronous active-low reset
//   i_stall, i_flush             hold the stage / load a bubble
//   i_bus_ack, i_data            fetch valid and fetched instruction word
//   i_pc, i_pc_p4                PC[31:2] and PC+4[31:2] of the fetched word
//   o_rs1, o_rs2, o_rd           register indices
//   o_pc, o_pc_p4                registered PCs
//   o_imm                        sign-extended immediate
//   o_reg_write .. o_alu_src     control flags
//   o_res_src                    00 ALU, 01 load, 10 PC+4, 11 PC+imm
//   o_funct3                     instr[14:12]
//   o_alu_ctrl                   ALU operation

module rv_decode_stage
  import rv_decode_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic        i_bus_ack,
  input  logic [31:0] i_data,
  input  logic [29:0] i_pc,
  input  logic [29:0] i_pc_p4,
  output logic [4:0]  o_rs1,
  output logic [4:0]  o_rs2,
  output logic [4:0]  o_rd,
  output logic [29:0] o_pc,
  output logic [29:0] o_pc_p4,
  output logic [31:0] o_imm,
  output logic        o_reg_write,
  output logic        o_mem_read,
  output logic        o_mem_write,
  output logic        o_jump,
  output logic        o_branch,
  output logic        o_alu_src,
  output logic [1:0]  o_res_src,
  output logic [2:0]  o_funct3,
  output logic [2:0]  o_alu_ctrl
);

  logic [31:0] instr_q;
  logic [29:0] pc_q;
  logic [29:0] pc_p4_q;

  // Stage register. A stall blocks the ack so a word delivered while
  // stalled is dropped; fetch is expected to re-present it.
  always_ff @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      instr_q <= NOP_INSTR;
      pc_q    <= '0;
      pc_p4_q <= '0;
    end else if (i_stall) begin
      instr_q <= instr_q;
      pc_q    <= pc_q;
      pc_p4_q <= pc_p4_q;
    end else if (i_bus_ack) begin
      instr_q <= i_data;
      pc_q    <= i_pc;
      pc_p4_q <= i_pc_p4;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  assign opcode = instr_q[6:0];
  assign funct3 = instr_q[14:12];

  logic      dec_reg_write;
  logic      dec_mem_read;
  logic      dec_mem_write;
  logic      dec_jump;
  logic      dec_branch;
  logic      dec_alu_src;
  res_src_e  dec_res_src;
  alu_ctrl_e dec_alu_ctrl;
  logic      uses_rs1;
  logic      uses_rs2;

  // Unlisted opcodes keep the all-zero defaults, which is the bubble decode.
  always_comb begin
    dec_reg_write = 1'b0;
    dec_mem_read  = 1'b0;
    dec_mem_write = 1'b0;
    dec_jump      = 1'b0;
    dec_branch    = 1'b0;
    dec_alu_src   = 1'b0;
    dec_res_src   = RES_ALU;
    dec_alu_ctrl  = ALU_ADD;
    uses_rs1      = 1'b1;
    uses_rs2      = 1'b0;
    case (opcode)
      OPC_OP: begin
        dec_reg_write = 1'b1;
        uses_rs2      = 1'b1;
        dec_alu_ctrl  = alu_ctrl_of_funct3(funct3);
        if (funct3 == 3'b000 && instr_q[30]) begin
          dec_alu_ctrl = ALU_SUB;
        end
      end
      OPC_OP_IMM: begin
        // funct7[5] only matters for SRAI, and it reaches the ALU via o_imm[10].
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_alu_ctrl  = alu_ctrl_of_funct3(funct3);
      end
      OPC_LOAD: begin
        dec_reg_write = 1'b1;
        dec_mem_read  = 1'b1;
        dec_alu_src   = 1'b1;
        dec_res_src   = RES_LOAD;
      end
      OPC_STORE: begin
        dec_mem_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs2      = 1'b1;
      end
      OPC_BRANCH: begin
        dec_branch   = 1'b1;
        dec_alu_ctrl = ALU_SUB;
        uses_rs2     = 1'b1;
      end
      OPC_JAL: begin
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        dec_res_src   = RES_PC_P4;
        uses_rs1      = 1'b0;
      end
      OPC_JALR: begin
        dec_jump      = 1'b1;
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        dec_res_src   = RES_PC_P4;
      end
      OPC_LUI: begin
        // rs1 forced to x0 so the ALU computes 0 + imm.
        dec_reg_write = 1'b1;
        dec_alu_src   = 1'b1;
        uses_rs1      = 1'b0;
      end
      OPC_AUIPC: begin
        dec_reg_write = 1'b1;
        dec_res_src   = RES_PC_IMM;
        uses_rs1      = 1'b0;
      end
      default: ;
    endcase
  end

  rv_imm_gen u_imm_gen (
    .instr (instr_q),
    .imm   (o_imm)
  );

  assign o_rs1       = uses_rs1 ? instr_q[19:15] : 5'd0;
  assign o_rs2       = uses_rs2 ? instr_q[24:20] : 5'd0;
  assign o_rd        = dec_reg_write ? instr_q[11:7] : 5'd0;
  assign o_pc        = pc_q;
  assign o_pc_p4     = pc_p4_q;
  assign o_reg_write = dec_reg_write;
  assign o_mem_read  = dec_mem_read;
  assign o_mem_write = dec_mem_write;
  assign o_jump      = dec_jump;
  assign o_branch    = dec_branch;
  assign o_alu_src   = dec_alu_src;
  assign o_res_src   = dec_res_src;
  assign o_funct3    = funct3;
  assign o_alu_ctrl  = dec_alu_ctrl;

endmodule

// File: tb/tb_rv_decode_stage.sv
// tb/tb_rv_decode_stage.sv - self-checking bench for rv_decode_stage

module tb_rv_decode_stage;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_stall = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_bus_ack = 1'b0;
  logic [31:0] i_data = 32'h0;
  logic [29:0] i_pc = 30'h0;
  logic [29:0] i_pc_p4 = 30'h0;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic [29:0] o_pc, o_pc_p4;
  logic [31:0] o_imm;
  logic        o_reg_write, o_mem_read, o_mem_write, o_jump, o_branch, o_alu_src;
  logic [1:0]  o_res_src;
  logic [2:0]  o_funct3, o_alu_ctrl;

  int tests = 0;
  int fails = 0;

  always #5 i_clk = ~i_clk;

  rv_decode_stage dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_stall(i_stall), .i_flush(i_flush),
    .i_bus_ack(i_bus_ack), .i_data(i_data), .i_pc(i_pc), .i_pc_p4(i_pc_p4),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_pc(o_pc), .o_pc_p4(o_pc_p4),
    .o_imm(o_imm), .o_reg_write(o_reg_write), .o_mem_read(o_mem_read),
    .o_mem_write(o_mem_write), .o_jump(o_jump), .o_branch(o_branch),
    .o_alu_src(o_alu_src), .o_res_src(o_res_src), .o_funct3(o_funct3),
    .o_alu_ctrl(o_alu_ctrl)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        rw, mr, mw, j, b, as;
    logic [1:0]  res;
    logic [2:0]  f3, alu;
  } dec_t;

  // ALU op by funct3: ADD SHIFT SLT SLTU XOR SHIFT OR AND
  logic [2:0] alu_tbl [0:7] = '{3'd0, 3'd7, 3'd5, 3'd6, 3'd4, 3'd7, 3'd3, 3'd2};

  function automatic dec_t model(input logic [31:0] w);
    dec_t d;
    byte  fmt;
    logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
    imm_i = {{20{w[31]}}, w[31:20]};
    imm_s = {{20{w[31]}}, w[31:25], w[11:7]};
    imm_b = {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    imm_u = {w[31:12], 12'h0};
    imm_j = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    d = '0;
    d.f3 = w[14:12];
    d.imm = imm_i;
    fmt = "X";
    case (w[6:0])
      7'h33: begin fmt = "R"; d.rw = 1; d.alu = alu_tbl[w[14:12]];
                   if (w[14:12] == 3'd0 && w[30]) d.alu = 3'd1; end
      7'h13: begin fmt = "I"; d.rw = 1; d.as = 1; d.alu = alu_tbl[w[14:12]]; end
      7'h03: begin fmt = "I"; d.rw = 1; d.mr = 1; d.as = 1; d.res = 2'd1; end
      7'h23: begin fmt = "S"; d.mw = 1; d.as = 1; d.imm = imm_s; end
      7'h63: begin fmt = "B"; d.b = 1; d.alu = 3'd1; d.imm = imm_b; end
      7'h6F: begin fmt = "J"; d.j = 1; d.rw = 1; d.res = 2'd2; d.imm = imm_j; end
      7'h67: begin fmt = "I"; d.j = 1; d.rw = 1; d.as = 1; d.res = 2'd2; end
      7'h37: begin fmt = "U"; d.rw = 1; d.as = 1; d.imm = imm_u; end
      7'h17: begin fmt = "U"; d.rw = 1; d.res = 2'd3; d.imm = imm_u; end
      default: ;
    endcase
    d.rs1 = (fmt == "U" || fmt == "J") ? 5'd0 : w[19:15];
    d.rs2 = (fmt == "R" || fmt == "S" || fmt == "B") ? w[24:20] : 5'd0;
    d.rd  = d.rw ? w[11:7] : 5'd0;
    return d;
  endfunction

  logic [31:0] m_instr = 32'h13;
  logic [29:0] m_pc = '0, m_pc4 = '0;

  always @(posedge i_clk) begin
    if (!i_reset_n || i_flush) begin
      m_instr <= 32'h13; m_pc <= '0; m_pc4 <= '0;
    end else if (!i_stall && i_bus_ack) begin
      m_instr <= i_data; m_pc <= i_pc; m_pc4 <= i_pc_p4;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge i_clk) begin
    dec_t e;
    e = model(m_instr);
    chk("rs1", 32'(o_rs1), 32'(e.rs1));
    chk("rs2", 32'(o_rs2), 32'(e.rs2));
    chk("rd", 32'(o_rd), 32'(e.rd));
    chk("imm", o_imm, e.imm);
    chk("pc", 32'(o_pc), 32'(m_pc));
    chk("pc_p4", 32'(o_pc_p4), 32'(m_pc4));
    chk("flags", {26'd0, o_reg_write, o_mem_read, o_mem_write, o_jump, o_branch, o_alu_src},
        {26'd0, e.rw, e.mr, e.mw, e.j, e.b, e.as});
    chk("res_src", 32'(o_res_src), 32'(e.res));
    chk("funct3", 32'(o_funct3), 32'(e.f3));
    chk("alu_ctrl", 32'(o_alu_ctrl), 32'(e.alu));
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input logic rst_n, input logic st, input logic fl, input logic ack,
                     input logic [31:0] w, input logic [29:0] pc);
    i_reset_n = rst_n; i_stall = st; i_flush = fl; i_bus_ack = ack;
    i_data = w; i_pc = pc; i_pc_p4 = pc + 30'd1;
    @(negedge i_clk);
  endtask

  task automatic chk_nop(input string p);
    chk({p, "_rw"}, 32'(o_reg_write), 32'd1);
    chk({p, "_as"}, 32'(o_alu_src), 32'd1);
    chk({p, "_alu"}, 32'(o_alu_ctrl), 32'd0);
    chk({p, "_rd"}, 32'(o_rd), 32'd0);
    chk({p, "_rs1"}, 32'(o_rs1), 32'd0);
    chk({p, "_imm"}, o_imm, 32'd0);
    chk({p, "_other"}, {o_mem_read, o_mem_write, o_jump, o_branch, o_res_src}, 32'd0);
    chk({p, "_pc"}, {o_pc, 2'b00}, 32'd0);
  endtask

  logic [6:0] opc_tbl [0:11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                  7'h67, 7'h37, 7'h17, 7'h0F, 7'h73, 7'h00};

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    cyc(0, 0, 0, 0, 32'h0, 30'h0);
    chk_nop("reset");

    cyc(1, 0, 0, 1, 32'h00500093, 30'h1);
    chk("addi_rd", 32'(o_rd), 32'd1);
    chk("addi_rs1", 32'(o_rs1), 32'd0);
    chk("addi_imm", o_imm, 32'd5);
    chk("addi_ctl", {o_reg_write, o_alu_src, o_alu_ctrl}, 32'b11_000);

    cyc(1, 0, 0, 1, 32'h40208133, 30'h2);
    chk("sub_alu", 32'(o_alu_ctrl), 32'd1);
    chk("sub_regs", {o_rs1, o_rs2, o_rd}, {17'd0, 5'd1, 5'd2, 5'd2});
    chk("sub_as", 32'(o_alu_src), 32'd0);

    cyc(1, 0, 0, 1, 32'hFE208EE3, 30'h3);
    chk("beq_branch", 32'(o_branch), 32'd1);
    chk("beq_imm", o_imm, 32'hFFFFFFFC);
    chk("beq_rd_rw", {o_rd, o_reg_write}, 32'd0);
    chk("beq_alu", 32'(o_alu_ctrl), 32'd1);

    cyc(1, 0, 0, 1, 32'h0080006F, 30'h10);
    chk("jal_jump", 32'(o_jump), 32'd1);
    chk("jal_imm", o_imm, 32'd8);
    chk("jal_res", 32'(o_res_src), 32'd2);
    chk("jal_rd", 32'(o_rd), 32'd0);
    chk("jal_pc", 32'(o_pc), 32'h10);

    cyc(1, 0, 0, 1, 32'h0000A183, 30'h5);
    chk("lw_ctl", {o_mem_read, o_res_src, o_rd}, {24'd0, 1'b1, 2'd1, 5'd3});
    cyc(1, 1, 1, 1, 32'h00500093, 30'h7);
    chk_nop("flush_stall");

    cyc(1, 0, 0, 1, 32'h0000A183, 30'h5);
    cyc(1, 1, 0, 1, 32'h40208133, 30'h9);
    chk("stall_hold", {o_mem_read, o_rd, o_pc[4:0]}, {21'd0, 1'b1, 5'd3, 5'd5});
    cyc(1, 0, 0, 0, 32'h40208133, 30'h9);
    chk("noack_hold", {o_mem_read, o_rd, o_pc[4:0]}, {21'd0, 1'b1, 5'd3, 5'd5});

    cyc(0, 1, 0, 1, 32'h40208133, 30'h9);
    chk_nop("reset_stall");

    cyc(1, 0, 0, 1, 32'h00000073, 30'h4);
    chk("ecall_ctl", {o_reg_write, o_mem_read, o_mem_write, o_jump, o_branch,
                      o_alu_src, o_res_src, o_alu_ctrl, o_rd}, 32'd0);

    cyc(1, 0, 0, 1, 32'h4030D093, 30'h6);   // srai x1,x1,3
    chk("srai_alu", 32'(o_alu_ctrl), 32'd7);
    chk("srai_imm10", 32'(o_imm[10]), 32'd1);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom();
      op = opc_tbl[$urandom_range(0, 11)];
      if (op == 7'h00) op = r[6:0];
      cyc(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 9) == 0), ($urandom_range(0, 9) < 7),
          {r[31:7], op}, 30'($urandom()));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
